// File: rtl/ws2812b_frame_scheduler.sv
// Frame scheduler for a ws2812b_controller: replays a double-buffered pixel store every
// refresh period, with global brightness scaling and optional ring rotation.
module ws2812b_frame_scheduler #(
   parameter int NB_LEDS        = 12,
   parameter int REFRESH_CYCLES = 2500000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        wr_en,
   input  logic [7:0]  wr_addr,
   input  logic [23:0] wr_rgb,
   input  logic        commit,
   input  logic [7:0]  brightness,
   input  logic        rotate_en,
   output logic [7:0]  address,
   output logic [7:0]  red,
   output logic [7:0]  green,
   output logic [7:0]  blue,
   output logic        load,
   output logic        latch_n,
   output logic        busy,
   output logic        frame_done,
   output logic        commit_pending
);

   localparam int AW  = (NB_LEDS > 1) ? $clog2(NB_LEDS) : 1;
   localparam int TW0 = $clog2(REFRESH_CYCLES) + 1;
   localparam int TW  = (TW0 < 9) ? 9 : TW0;

   typedef enum logic [1:0] {S_WAIT, S_LOAD, S_LATCH} state_t;

   state_t         state, state_nx;
   logic [TW-1:0]  timer, timer_nx;
   logic           front_sel, front_nx;
   logic [7:0]     rot_off, rot_nx;
   logic           pend_nx;
   logic [23:0]    fb [2][NB_LEDS];
   logic [8:0]     sum;
   logic [AW-1:0]  idx;
   logic [23:0]    pix;

   function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] b);
      return 8'(({8'd0, c} * ({8'd0, b} + 16'd1)) >> 8);
   endfunction

   // State register and frame bookkeeping
   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= S_WAIT;
         timer          <= '0;
         front_sel      <= 1'b0;
         rot_off        <= 8'd0;
         commit_pending <= 1'b0;
         frame_done     <= 1'b0;
      end else begin
         state          <= state_nx;
         timer          <= timer_nx;
         front_sel      <= front_nx;
         rot_off        <= rot_nx;
         commit_pending <= pend_nx;
         frame_done     <= (state == S_LATCH);
      end
   end

   // Writes always target the buffer that is not being displayed right now
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int b = 0; b < 2; b++)
            for (int i = 0; i < NB_LEDS; i++)
               fb[b][i] <= 24'd0;
      end else if (wr_en && (wr_addr < 8'(NB_LEDS))) begin
         fb[~front_sel][AW'(wr_addr)] <= wr_rgb;
      end
   end

   always_comb begin
      state_nx = state;
      timer_nx = timer + 1'b1;
      front_nx = front_sel;
      rot_nx   = rot_off;
      pend_nx  = commit_pending | commit;
      case (state)
         S_WAIT: begin
            if (timer == TW'(REFRESH_CYCLES - 1)) begin
               state_nx = S_LOAD;
               timer_nx = '0;
               if (commit_pending || commit) begin
                  front_nx = ~front_sel;
                  rot_nx   = 8'd0;
                  pend_nx  = 1'b0;
               end
            end
         end
         S_LOAD: begin
            if (timer == TW'(NB_LEDS - 1)) begin
               state_nx = S_LATCH;
               timer_nx = '0;
            end
         end
         S_LATCH: begin
            state_nx = S_WAIT;
            timer_nx = '0;
            if (rotate_en)
               rot_nx = (rot_off == 8'(NB_LEDS - 1)) ? 8'd0 : rot_off + 8'd1;
         end
         default: begin
            state_nx = S_WAIT;
            timer_nx = '0;
         end
      endcase
   end

   // Source pixel for slot k is (k - rot_off) mod NB_LEDS, kept non-negative
   always_comb begin
      sum = {1'b0, timer[7:0]} + 9'(NB_LEDS) - {1'b0, rot_off};
      idx = AW'((sum >= 9'(NB_LEDS)) ? (sum - 9'(NB_LEDS)) : sum);
      pix = fb[front_sel][idx];
   end

   always_comb begin
      load    = (state == S_LOAD);
      latch_n = (state != S_LATCH);
      busy    = (state != S_WAIT);
      address = 8'd0;
      red     = 8'd0;
      green   = 8'd0;
      blue    = 8'd0;
      if (state == S_LOAD) begin
         address = timer[7:0];
         red     = scale(pix[23:16], brightness);
         green   = scale(pix[15:8],  brightness);
         blue    = scale(pix[7:0],   brightness);
      end
   end

endmodule

// File: tb/tb_ws2812b_frame_scheduler.sv
// Scoreboard bench: stimulus queues each frame's expected pixels, a negedge monitor
// pops one entry per load strobe and also checks latch/frame_done/busy framing.
module tb_ws2812b_frame_scheduler;
   localparam int NB = 12;
   localparam int RC = 20;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        wr_en = 1'b0;
   logic [7:0]  wr_addr = 8'd0;
   logic [23:0] wr_rgb = 24'd0;
   logic        commit = 1'b0;
   logic [7:0]  brightness = 8'hFF;
   logic        rotate_en = 1'b0;
   logic [7:0]  address, red, green, blue;
   logic        load, latch_n, busy, frame_done, commit_pending;

   int tests = 0;
   int fails = 0;
   logic [31:0] exp_q[$];

   ws2812b_frame_scheduler #(.NB_LEDS(NB), .REFRESH_CYCLES(RC)) dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_rgb(wr_rgb),
      .commit(commit), .brightness(brightness), .rotate_en(rotate_en),
      .address(address), .red(red), .green(green), .blue(blue), .load(load),
      .latch_n(latch_n), .busy(busy), .frame_done(frame_done),
      .commit_pending(commit_pending)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Expected frame: all zero except up to two hand-computed (already scaled) pixels
   task automatic push_frame(input int a0, input logic [23:0] v0,
                             input int a1, input logic [23:0] v1);
      logic [23:0] v;
      for (int k = 0; k < NB; k++) begin
         v = (k == a0) ? v0 : ((k == a1) ? v1 : 24'd0);
         exp_q.push_back({8'(k), v});
      end
   endtask

   task automatic write_px(input logic [7:0] a, input logic [23:0] v);
      wr_en = 1'b1; wr_addr = a; wr_rgb = v;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic pulse_commit();
      commit = 1'b1;
      @(negedge clk);
      commit = 1'b0;
   endtask

   task automatic wait_load(output int n);
      n = 0;
      while (!load && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!load) begin
         tests++; fails++;
         $display("FAIL wait_load: got timeout expected load");
      end
   endtask

   // Returns on the first WAIT cycle after the latch
   task automatic wait_latch();
      int n = 0;
      while (latch_n && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (latch_n) begin
         tests++; fails++;
         $display("FAIL wait_latch: got timeout expected latch");
      end
      @(negedge clk);
   endtask

   // Monitor
   int   cyc = 0;
   int   last_lat = 0;
   logic lat_ok = 1'b0;
   logic prev_load = 1'b0;
   logic prev_latch = 1'b0;
   logic [7:0] prev_addr = 8'd0;
   logic [31:0] e;

   always @(negedge clk) begin
      if (reset) begin
         lat_ok = 1'b0; prev_load = 1'b0; prev_latch = 1'b0; prev_addr = 8'd0;
      end else begin
         if (load) begin
            if (exp_q.size() == 0) chk("pixel_unexpected", {address, red, green, blue}, 32'hFFFF_FFFF);
            else begin
               e = exp_q.pop_front();
               chk("pixel", {address, red, green, blue}, e);
            end
            if (!prev_load && lat_ok) chk("wait_len", cyc - last_lat, RC + 1);
         end
         if (!latch_n) begin
            chk("latch_after_last_load", {31'd0, prev_load && (prev_addr == 8'(NB - 1)) && !load}, 32'd1);
            last_lat = cyc; lat_ok = 1'b1;
         end
         if (frame_done || prev_latch) chk("frame_done", {31'd0, frame_done}, {31'd0, prev_latch});
         if (busy || load || !latch_n) chk("busy", {31'd0, busy}, {31'd0, load || !latch_n});
         prev_load = load; prev_latch = !latch_n; prev_addr = address;
      end
      cyc++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      push_frame(-1, 24'd0, -1, 24'd0);
      @(negedge clk);
      @(negedge clk);
      chk("rst_load", {31'd0, load}, 32'd0);
      chk("rst_latch_n", {31'd0, latch_n}, 32'd1);
      chk("rst_outs", {address, red, green, blue}, 32'd0);
      chk("rst_flags", {29'd0, busy, frame_done, commit_pending}, 32'd0);
      reset = 1'b0;
      wait_load(n);
      chk("first_load_delay", n, RC);
      wait_latch();

      // Write + double commit in WAIT -> shown next frame, one swap
      write_px(8'd3, 24'hFF8000);
      pulse_commit();
      pulse_commit();
      chk("pending_set", {31'd0, commit_pending}, 32'd1);
      push_frame(3, 24'hFF8000, -1, 24'd0);
      wait_load(n);
      chk("pending_clr", {31'd0, commit_pending}, 32'd0);
      wait_latch();

      // Brightness scaling
      write_px(8'd0, 24'hFF8001);
      brightness = 8'h7F;
      pulse_commit();
      push_frame(0, 24'h7F4000, -1, 24'd0);
      wait_latch();
      brightness = 8'h00;
      push_frame(-1, 24'd0, -1, 24'd0);
      wait_latch();
      brightness = 8'hFF;
      push_frame(0, 24'hFF8001, -1, 24'd0);
      wait_latch();

      // Rotation over a full ring plus wrap
      write_px(8'd3, 24'd0);
      write_px(8'd0, 24'h200000);
      rotate_en = 1'b1;
      pulse_commit();
      for (int i = 0; i <= NB; i++) begin
         push_frame(i % NB, 24'h200000, -1, 24'd0);
         wait_latch();
      end
      rotate_en = 1'b0;
      push_frame(1, 24'h200000, -1, 24'd0);
      wait_latch();
      push_frame(1, 24'h200000, -1, 24'd0);
      wait_latch();
      pulse_commit();
      push_frame(0, 24'hFF8001, -1, 24'd0);
      wait_latch();

      // Out-of-range write is dropped
      write_px(8'd12, 24'hFFFFFF);
      pulse_commit();
      push_frame(0, 24'h200000, -1, 24'd0);
      wait_latch();

      // Commit during LOAD takes effect one frame later
      write_px(8'd5, 24'h010203);
      push_frame(0, 24'h200000, -1, 24'd0);
      wait_load(n);
      pulse_commit();
      chk("pending_load", {31'd0, commit_pending}, 32'd1);
      push_frame(0, 24'hFF8001, 5, 24'h010203);
      wait_latch();
      wait_latch();

      // Reset on the 5th LOAD cycle
      push_frame(0, 24'hFF8001, 5, 24'h010203);
      wait_load(n);
      repeat (4) @(negedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      chk("abort_load", {31'd0, load}, 32'd0);
      chk("abort_latch_n", {31'd0, latch_n}, 32'd1);
      chk("abort_outs", {address, red, green, blue}, 32'd0);
      chk("abort_flags", {29'd0, busy, frame_done, commit_pending}, 32'd0);
      chk("abort_consumed", exp_q.size(), NB - 5);
      exp_q.delete();
      push_frame(-1, 24'd0, -1, 24'd0);
      @(negedge clk);
      reset = 1'b0;
      wait_load(n);
      chk("reload_delay", n, RC);
      wait_latch();

      chk("queue_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
